// File: rtl/riscv_run_ctrl_pkg.sv
// Shared types and constants for the RISC-V run controller.
package riscv_run_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   localparam int unsigned TOHOST_PASS         = 1;
   localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_00FC;

endpackage

// File: rtl/run_ctrl_watchdog.sv
// RUN-cycle counter with clear/enable, saturation and watchdog expiry compare.
// Expiry compare only exists when RISCV_RUN_CTRL_WATCHDOG_EN is defined.
module run_ctrl_watchdog #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned MAX_CYCLES = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired_c
);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

`ifdef RISCV_RUN_CTRL_WATCHDOG_EN
   assign expired_c = (count == CNT_W'(MAX_CYCLES - 1));
`else
   assign expired_c = 1'b0;
`endif

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: core reset sequencing, tohost exit decode and RUN-cycle watchdog.
// Optional watchdog/TIMEOUT enabled by RISCV_RUN_CTRL_WATCHDOG_EN.
module riscv_run_ctrl
   import riscv_run_ctrl_pkg::*;
#(
   parameter int unsigned       XLEN        = 32,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       RST_CYCLES  = 2,
   parameter int unsigned       MAX_CYCLES  = 25,
   parameter int unsigned       CNT_W       = 16,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [XLEN-1:0]   mem_wdata,
   output logic              core_rst,
   output logic              run,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [XLEN-2:0]   exit_code,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t            state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              exit_odd, wd_clr, wd_en, wd_expired, capture;

   // Only odd tohost writes terminate; even data is treated as ordinary stores.
   assign exit_odd = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];

   run_ctrl_watchdog #(
      .CNT_W      (CNT_W),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear     (wd_clr),
      .enable    (wd_en),
      .count     (cycle_count),
      .expired_c (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_HOLD;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      wd_clr    = 1'b0;
      wd_en     = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_HOLD: begin
            if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
               state_nxt = ST_RUN;
               hold_nxt  = '0;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            // Exit write beats a simultaneous watchdog expiry and freezes the count.
            wd_en = !exit_odd;
            if (exit_odd && (mem_wdata == XLEN'(TOHOST_PASS))) begin
               state_nxt = ST_PASS;
            end else if (exit_odd) begin
               state_nxt = ST_FAIL;
               capture   = 1'b1;
            end else if (wd_expired) begin
               state_nxt = ST_TIMEOUT;
            end
         end
         ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            if (restart) begin
               state_nxt = ST_HOLD;
               wd_clr    = 1'b1;
            end
         end
         default: state_nxt = ST_HOLD;
      endcase
   end

   // Outputs registered from the next state so they reflect the post-edge state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         core_rst  <= 1'b1;
         run       <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         exit_code <= '0;
      end else begin
         core_rst <= (state_nxt != ST_RUN);
         run      <= (state_nxt == ST_RUN);
         done     <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL) ||
                     (state_nxt == ST_TIMEOUT);
         pass     <= (state_nxt == ST_PASS);
         fail     <= (state_nxt == ST_FAIL);
         if (capture) begin
            exit_code <= mem_wdata[XLEN-1:1];
         end else if (wd_clr) begin
            exit_code <= '0;
         end
      end
   end

`ifdef RISCV_RUN_CTRL_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         timeout <= 1'b0;
      end else begin
         timeout <= (state_nxt == ST_TIMEOUT);
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule
